prbs4_checker: RTL and testbench

Receive-side checker for the 4-bit PRBS word stream produced by the team's LFSR sequence generator (polynomial x^4+x^3+1, next word = {w[2:0], w[3]^w[2]}, period 15). It self-synchronises to the incoming stream, declares lock after a run of correct words, and then flywheels the expected sequence to count word errors. It sits at the far end of a link or loopback path and provides lock, error-pulse and saturating error-count status for BIST and link bring-up.

---
 rtl/prbs4_checker.sv | 120 ++++++++++++
 tb/tb_prbs4_checker.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/prbs4_checker.sv
// rtl/prbs4_checker.sv - self-synchronising checker for the x^4+x^3+1 PRBS word stream
module prbs4_checker #(
    parameter int LOCK_CNT   = 4,
    parameter int UNLOCK_CNT = 3,
    parameter int ERR_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [3:0]       in_data,
    input  logic             clr_err,
    output logic             locked,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_count,
    output logic             zero_det
);

    typedef enum logic {HUNT, LOCKED} state_t;

    state_t           state, state_nx;
    logic [3:0]       ref_word, ref_nx;
    logic             have_ref, have_ref_nx;
    logic [3:0]       match_cnt, match_nx;
    logic [3:0]       miss_cnt, miss_nx;
    logic [ERR_W-1:0] err_count_nx;
    logic             err_pulse_nx, zero_det_nx;
    logic [3:0]       predicted;

    assign predicted = {ref_word[2:0], ref_word[3] ^ ref_word[2]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= HUNT;
            ref_word  <= 4'd0;
            have_ref  <= 1'b0;
            match_cnt <= 4'd0;
            miss_cnt  <= 4'd0;
            err_count <= '0;
            err_pulse <= 1'b0;
            zero_det  <= 1'b0;
            locked    <= 1'b0;
        end else begin
            state     <= state_nx;
            ref_word  <= ref_nx;
            have_ref  <= have_ref_nx;
            match_cnt <= match_nx;
            miss_cnt  <= miss_nx;
            err_count <= err_count_nx;
            err_pulse <= err_pulse_nx;
            zero_det  <= zero_det_nx;
            locked    <= (state_nx == LOCKED);
        end
    end

    always_comb begin
        state_nx     = state;
        ref_nx       = ref_word;
        have_ref_nx  = have_ref;
        match_nx     = match_cnt;
        miss_nx      = miss_cnt;
        err_count_nx = err_count;
        err_pulse_nx = 1'b0;
        zero_det_nx  = 1'b0;

        if (clr_err) begin
            err_count_nx = '0;
        end

        if (in_valid) begin
            zero_det_nx = (in_data == 4'd0);
            case (state)
                HUNT: begin
                    if (in_data == 4'd0) begin
                        have_ref_nx = 1'b0;
                        match_nx    = 4'd0;
                    end else if (!have_ref) begin
                        ref_nx      = in_data;
                        have_ref_nx = 1'b1;
                        match_nx    = 4'd0;
                    end else if (in_data == predicted) begin
                        ref_nx = in_data;
                        if (match_cnt == 4'(LOCK_CNT - 1)) begin
                            state_nx = LOCKED;
                            match_nx = 4'd0;
                            miss_nx  = 4'd0;
                        end else begin
                            match_nx = match_cnt + 4'd1;
                        end
                    end else begin
                        ref_nx   = in_data;
                        match_nx = 4'd0;
                    end
                end
                LOCKED: begin
                    if (in_data == predicted) begin
                        ref_nx  = in_data;
                        miss_nx = 4'd0;
                    end else begin
                        err_pulse_nx = 1'b1;
                        if (!clr_err && (err_count != '1)) begin
                            err_count_nx = err_count + ERR_W'(1);
                        end
                        // Flywheel: keep predicting from the model, not the corrupt word.
                        ref_nx = predicted;
                        if (miss_cnt == 4'(UNLOCK_CNT - 1)) begin
                            state_nx    = HUNT;
                            have_ref_nx = 1'b0;
                            match_nx    = 4'd0;
                            miss_nx     = 4'd0;
                        end else begin
                            miss_nx = miss_cnt + 4'd1;
                        end
                    end
                end
                default: state_nx = HUNT;
            endcase
        end
    end

endmodule

// File: tb/tb_prbs4_checker.sv
// tb/tb_prbs4_checker.sv - vector table, corner sequences and randomized model check for prbs4_checker
module tb_prbs4_checker;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [3:0]  in_data = 4'd0;
    logic        clr_err = 1'b0;
    logic        locked, err_pulse, zero_det;
    logic [15:0] err_count;
    logic        s_locked, s_err_pulse, s_zero_det;
    logic [1:0]  s_err_count;

    always #5 clk = ~clk;

    prbs4_checker dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .clr_err(clr_err),
        .locked(locked), .err_pulse(err_pulse), .err_count(err_count), .zero_det(zero_det)
    );

    prbs4_checker #(.LOCK_CNT(4), .UNLOCK_CNT(15), .ERR_W(2)) dut_s (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .clr_err(clr_err),
        .locked(s_locked), .err_pulse(s_err_pulse), .err_count(s_err_count), .zero_det(s_zero_det)
    );

    int checks = 0;
    int passed = 0;

    // The full period of the generator starting from seed 0001.
    logic [3:0] seq [15] = '{4'h1, 4'h2, 4'h4, 4'h9, 4'h3, 4'h6, 4'hD, 4'hA,
                             4'h5, 4'hB, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8};

    function automatic logic [3:0] succ(input logic [3:0] w);
        for (int i = 0; i < 15; i++) if (seq[i] == w) return seq[(i + 1) % 15];
        return 4'h0;
    endfunction

    bit         m_locked, m_have, m_pulse, m_zero;
    int         m_match, m_miss, m_cnt;
    logic [3:0] m_ref;

    task automatic model(input bit r, input bit v, input logic [3:0] d, input bit c);
        m_pulse = 0;
        m_zero  = 0;
        if (r) begin
            m_locked = 0; m_have = 0; m_match = 0; m_miss = 0; m_cnt = 0; m_ref = 4'h0;
        end else begin
            if (c) m_cnt = 0;
            if (v) begin
                if (d == 4'h0) m_zero = 1;
                if (!m_locked) begin
                    if (d == 4'h0) begin
                        m_have = 0; m_match = 0;
                    end else if (!m_have) begin
                        m_ref = d; m_have = 1; m_match = 0;
                    end else if (d == succ(m_ref)) begin
                        m_ref = d; m_match++;
                        if (m_match == 4) begin m_locked = 1; m_miss = 0; m_match = 0; end
                    end else begin
                        m_ref = d; m_match = 0;
                    end
                end else if (d == succ(m_ref)) begin
                    m_ref = d; m_miss = 0;
                end else begin
                    m_pulse = 1;
                    if (!c && m_cnt < 65535) m_cnt++;
                    m_ref = succ(m_ref);
                    m_miss++;
                    if (m_miss == 3) begin m_locked = 0; m_have = 0; m_match = 0; m_miss = 0; end
                end
            end
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    endtask

    task automatic cyc(input bit r, input bit v, input logic [3:0] d, input bit c);
        rst = r; in_valid = v; in_data = d; clr_err = c;
        @(posedge clk);
        #1;
        model(r, v, d, c);
        check("model", {13'd0, locked, err_pulse, zero_det, err_count},
              {13'd0, m_locked, m_pulse, m_zero, m_cnt[15:0]});
    endtask

    typedef struct {
        bit r; bit v; logic [3:0] d; bit c;
        bit el; bit ep; bit ez; logic [15:0] ec;
    } vec_t;
    vec_t vt[$];

    task automatic add(input bit r, input bit v, input logic [3:0] d, input bit c,
                       input bit el, input bit ep, input bit ez, input logic [15:0] ec);
        vec_t x;
        x.r = r; x.v = v; x.d = d; x.c = c; x.el = el; x.ep = ep; x.ez = ez; x.ec = ec;
        vt.push_back(x);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        // reset, then lock on 0001..0011
        add(1,0,4'h0,0, 0,0,0,0);
        add(0,1,4'h1,0, 0,0,0,0); add(0,1,4'h2,0, 0,0,0,0); add(0,1,4'h4,0, 0,0,0,0);
        add(0,1,4'h9,0, 0,0,0,0); add(0,1,4'h3,0, 1,0,0,0);
        // single error then flywheel recovery, then a gap
        add(0,1,4'h7,0, 1,1,0,1); add(0,1,4'hD,0, 1,0,0,1); add(0,1,4'hA,0, 1,0,0,1);
        add(0,0,4'hF,0, 1,0,0,1);
        // three misses drop lock, then relock
        add(0,1,4'hF,0, 1,1,0,2); add(0,1,4'hF,0, 1,1,0,3); add(0,1,4'hF,0, 0,1,0,4);
        add(0,1,4'h1,0, 0,0,0,4); add(0,1,4'h2,0, 0,0,0,4); add(0,1,4'h4,0, 0,0,0,4);
        add(0,1,4'h9,0, 0,0,0,4); add(0,1,4'h3,0, 1,0,0,4);
        // clr_err on a zero mismatch: pulse but count cleared
        add(0,1,4'h0,1, 1,1,1,0); add(0,1,4'hD,0, 1,0,0,0);
        // zero in hunt, then seed repeat takes one extra word
        add(1,0,4'h0,0, 0,0,0,0); add(0,1,4'h0,0, 0,0,1,0);
        add(0,1,4'h1,0, 0,0,0,0); add(0,1,4'h1,0, 0,0,0,0); add(0,1,4'h2,0, 0,0,0,0);
        add(0,1,4'h4,0, 0,0,0,0); add(0,1,4'h9,0, 0,0,0,0); add(0,1,4'h3,0, 1,0,0,0);

        foreach (vt[i]) begin
            cyc(vt[i].r, vt[i].v, vt[i].d, vt[i].c);
            check($sformatf("vec%0d", i), {13'd0, locked, err_pulse, zero_det, err_count},
                  {13'd0, vt[i].el, vt[i].ep, vt[i].ez, vt[i].ec});
        end

        // saturation on the ERR_W=2 instance: errors alternate with good words
        begin
            logic [3:0] words [10] = '{4'h0, 4'hD, 4'hF, 4'h5, 4'hF, 4'h7, 4'h1, 4'hE, 4'h1, 4'hC};
            int zeros = 0;
            int errs  = 0;
            cyc(1, 0, 4'h0, 0);
            foreach (seq[i]) if (i < 5) cyc(0, 1, seq[i], 0);
            check("sat_lock", s_locked, 1);
            for (int i = 0; i < 10; i++) begin
                cyc(0, 1, words[i], 0);
                if (s_zero_det) zeros++;
                if (i % 2 == 0) begin
                    errs++;
                    check($sformatf("sat_pulse%0d", i), s_err_pulse, 1);
                    check($sformatf("sat_cnt%0d", i), s_err_count, (errs > 3) ? 3 : errs);
                end
            end
            check("sat_zero_pulses", zeros, 1);
            check("sat_still_locked", s_locked, 1);
            // reset while locked with nonzero counts
            cyc(1, 1, 4'h5, 0);
            check("rst_s", {s_locked, s_err_pulse, s_zero_det, s_err_count}, 0);
            check("rst_d", {locked, err_pulse, zero_det, err_count}, 0);
        end

        // randomized stream against the model
        begin
            int gi = 0;
            for (int n = 0; n < 2000; n++) begin
                bit r, v, c;
                logic [3:0] d;
                r = ($urandom % 150 == 0);
                v = ($urandom % 5 != 0);
                c = ($urandom % 16 == 0);
                d = seq[gi];
                if ($urandom % 8 == 0) d = 4'($urandom % 16);
                if (v) gi = (gi + 1) % 15;
                cyc(r, v, d, c);
            end
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
